// File: rtl/conv1_pkg.sv
// Shared types and constants for the conv1 window sequencer.
// Optional build macro CONV1_PAD_EN is consumed by conv1_addr_gen and conv1_sched.
package conv1_pkg;

    typedef enum logic [2:0] {
        IDLE,
        FETCH,
        WAIT_RD,
        FIRE,
        LAT,
        OUT,
        DONE
    } state_e;

    localparam int CONV1_K       = 3;
    localparam int CONV1_TAPS    = 9;
    localparam int CONV1_FILTERS = 32;

    typedef logic [31:0] word_t;

    // Row offset of window tap k (k = 3*dy + dx), without a divider.
    function automatic logic [1:0] tapDy(input logic [3:0] k);
        case (k)
            4'd0, 4'd1, 4'd2: tapDy = 2'd0;
            4'd3, 4'd4, 4'd5: tapDy = 2'd1;
            4'd6, 4'd7, 4'd8: tapDy = 2'd2;
            default:          tapDy = 2'd0;
        endcase
    endfunction

    function automatic logic [1:0] tapDx(input logic [3:0] k);
        case (k)
            4'd0, 4'd3, 4'd6: tapDx = 2'd0;
            4'd1, 4'd4, 4'd7: tapDx = 2'd1;
            4'd2, 4'd5, 4'd8: tapDx = 2'd2;
            default:          tapDx = 2'd0;
        endcase
    endfunction

endpackage

// File: rtl/conv1_addr_gen.sv
// Maps (output row, output column, tap k) to a row-major read address and an in-bounds flag.
// With CONV1_PAD_EN the window is centred on the position and taps outside the map are flagged.
module conv1_addr_gen
    import conv1_pkg::*;
#(
    parameter int IMG_W  = 28,
    parameter int IMG_H  = 28,
    parameter int ADDR_W = $clog2(IMG_W * IMG_H)
) (
    input  logic [ADDR_W-1:0] row_i,
    input  logic [ADDR_W-1:0] col_i,
    input  logic [3:0]        k_i,
    output logic [ADDR_W-1:0] addr_o,
    output logic              inBounds_o
);

    localparam logic [ADDR_W-1:0] IMG_W_A = ADDR_W'(IMG_W);
    localparam logic [ADDR_W-1:0] IMG_H_A = ADDR_W'(IMG_H);

    logic [ADDR_W-1:0] dy;
    logic [ADDR_W-1:0] dx;
    logic [ADDR_W-1:0] srcRow;
    logic [ADDR_W-1:0] srcCol;

    assign dy = ADDR_W'(tapDy(k_i));
    assign dx = ADDR_W'(tapDx(k_i));

`ifdef CONV1_PAD_EN
    // Work in padded coordinates (source + 1) so "one left of column 0" is 0, not a wrap.
    logic [ADDR_W-1:0] padRow;
    logic [ADDR_W-1:0] padCol;

    assign padRow     = row_i + dy;
    assign padCol     = col_i + dx;
    assign inBounds_o = (padRow != '0) && (padRow <= IMG_H_A) &&
                        (padCol != '0) && (padCol <= IMG_W_A);
    assign srcRow     = padRow - ADDR_W'(1);
    assign srcCol     = padCol - ADDR_W'(1);
`else
    assign srcRow     = row_i + dy;
    assign srcCol     = col_i + dx;
    assign inBounds_o = (srcRow < IMG_H_A) && (srcCol < IMG_W_A);
`endif

    assign addr_o = inBounds_o ? (srcRow * IMG_W_A + srcCol) : '0;

endmodule

// File: rtl/conv1_sched.sv
// Window sequencer for the conv1 filter bank: fetches 3x3 windows, waits out the filter latency, hands off tags.
// Build macro CONV1_PAD_EN selects zero-padded (same-size) output instead of valid-only output.
module conv1_sched
    import conv1_pkg::*;
#(
    parameter int IMG_W    = 28,
    parameter int IMG_H    = 28,
    parameter int FILT_LAT = 2,
    parameter int ADDR_W   = $clog2(IMG_W * IMG_H)
) (
    input  logic                clk,
    input  logic                rst_n,
    input  logic                start,
    output logic                busy,
    output logic                done,
    output logic                mem_rd_en,
    output logic [ADDR_W-1:0]   mem_addr,
    input  logic [31:0]         mem_rdata,
    output logic [0:8][31:0]    win_data,
    output logic                win_valid,
    output logic                out_valid,
    input  logic                out_ready,
    output logic [ADDR_W-1:0]   out_row,
    output logic [ADDR_W-1:0]   out_col
);

`ifdef CONV1_PAD_EN
    localparam int OH = IMG_H;
    localparam int OW = IMG_W;
`else
    localparam int OH = IMG_H - 2;
    localparam int OW = IMG_W - 2;
`endif

    localparam int LAT_W = (FILT_LAT > 2) ? $clog2(FILT_LAT) : 1;
    localparam logic [ADDR_W-1:0] LAST_ROW = ADDR_W'(OH - 1);
    localparam logic [ADDR_W-1:0] LAST_COL = ADDR_W'(OW - 1);
    localparam logic [3:0]        LAST_TAP = 4'(CONV1_TAPS - 1);

    state_e            state_q;
    logic [ADDR_W-1:0] row_q;
    logic [ADDR_W-1:0] col_q;
    logic [3:0]        k_q;
    logic [LAT_W-1:0]  latCnt_q;
    logic              capValid_q;
    logic [3:0]        capIdx_q;
    logic              capPad_q;
    logic              busy_q;
    logic              done_q;
    logic              rdEn_q;
    logic [ADDR_W-1:0] addr_q;
    logic              winValid_q;
    logic              outValid_q;
    logic [0:8][31:0]  winData_q;

    logic [ADDR_W-1:0] slotRow_d;
    logic [ADDR_W-1:0] slotCol_d;
    logic [3:0]        slotK_d;
    logic [ADDR_W-1:0] slotAddr;
    logic              slotInBounds;
    logic              lastPos;

    assign lastPos = (row_q == LAST_ROW) && (col_q == LAST_COL);

    // The read strobe and address are registered, so look up the slot that the next cycle will present.
    always_comb begin
        slotRow_d = row_q;
        slotCol_d = col_q;
        slotK_d   = 4'd0;
        case (state_q)
            IDLE: begin
                slotRow_d = '0;
                slotCol_d = '0;
            end
            FETCH: begin
                slotK_d = k_q + 4'd1;
            end
            OUT: begin
                if (col_q == LAST_COL) begin
                    slotRow_d = row_q + ADDR_W'(1);
                    slotCol_d = '0;
                end else begin
                    slotCol_d = col_q + ADDR_W'(1);
                end
            end
            default: ;
        endcase
    end

    conv1_addr_gen #(
        .IMG_W  (IMG_W),
        .IMG_H  (IMG_H),
        .ADDR_W (ADDR_W)
    ) u_addr_gen (
        .row_i      (slotRow_d),
        .col_i      (slotCol_d),
        .k_i        (slotK_d),
        .addr_o     (slotAddr),
        .inBounds_o (slotInBounds)
    );

    // Main sequencer; each read's data lands in the window one cycle after its slot, tagged by capIdx/capPad.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q    <= IDLE;
            row_q      <= '0;
            col_q      <= '0;
            k_q        <= '0;
            latCnt_q   <= '0;
            capValid_q <= 1'b0;
            capIdx_q   <= '0;
            capPad_q   <= 1'b0;
            busy_q     <= 1'b0;
            done_q     <= 1'b0;
            rdEn_q     <= 1'b0;
            addr_q     <= '0;
            winValid_q <= 1'b0;
            outValid_q <= 1'b0;
            winData_q  <= '0;
        end else begin
            winValid_q <= 1'b0;
            done_q     <= 1'b0;
            capValid_q <= 1'b0;

            if (capValid_q) begin
                winData_q[capIdx_q] <= capPad_q ? 32'd0 : mem_rdata;
            end

            case (state_q)
                IDLE: begin
                    if (start) begin
                        state_q <= FETCH;
                        busy_q  <= 1'b1;
                        row_q   <= '0;
                        col_q   <= '0;
                        k_q     <= '0;
                        rdEn_q  <= slotInBounds;
                        addr_q  <= slotAddr;
                    end
                end

                FETCH: begin
                    capValid_q <= 1'b1;
                    capIdx_q   <= k_q;
                    capPad_q   <= ~rdEn_q;
                    if (k_q == LAST_TAP) begin
                        rdEn_q  <= 1'b0;
                        state_q <= WAIT_RD;
                    end else begin
                        k_q    <= k_q + 4'd1;
                        rdEn_q <= slotInBounds;
                        addr_q <= slotAddr;
                    end
                end

                WAIT_RD: begin
                    state_q    <= FIRE;
                    winValid_q <= 1'b1;
                end

                FIRE: begin
                    latCnt_q <= LAT_W'(FILT_LAT - 1);
                    if (FILT_LAT == 1) begin
                        state_q    <= OUT;
                        outValid_q <= 1'b1;
                    end else begin
                        state_q <= LAT;
                    end
                end

                LAT: begin
                    latCnt_q <= latCnt_q - LAT_W'(1);
                    if (latCnt_q == LAT_W'(1)) begin
                        state_q    <= OUT;
                        outValid_q <= 1'b1;
                    end
                end

                OUT: begin
                    if (out_ready) begin
                        outValid_q <= 1'b0;
                        if (lastPos) begin
                            state_q <= DONE;
                            done_q  <= 1'b1;
                            busy_q  <= 1'b0;
                        end else begin
                            row_q   <= slotRow_d;
                            col_q   <= slotCol_d;
                            k_q     <= '0;
                            state_q <= FETCH;
                            rdEn_q  <= slotInBounds;
                            addr_q  <= slotAddr;
                        end
                    end
                end

                DONE: begin
                    state_q <= IDLE;
                end

                default: begin
                    state_q <= IDLE;
                end
            endcase
        end
    end

    assign busy      = busy_q;
    assign done      = done_q;
    assign mem_rd_en = rdEn_q;
    assign mem_addr  = addr_q;
    assign win_data  = winData_q;
    assign win_valid = winValid_q;
    assign out_valid = outValid_q;
    assign out_row   = row_q;
    assign out_col   = col_q;

endmodule

// File: tb/tb_conv1_sched.sv
// Scoreboard bench for conv1_sched on a 4x4 map (word[a] = a); a second instance runs FILT_LAT=1.
// Expectations follow CONV1_PAD_EN when it is defined for the build.
module tb_conv1_sched;

    localparam int W  = 4;
    localparam int H  = 4;
    localparam int FL = 2;
    localparam int AW = $clog2(W * H);

    typedef logic [0:8][31:0] win_t;

`ifdef CONV1_PAD_EN
    localparam int   OH = 4;
    localparam int   OW = 4;
    localparam int   EXP_READS = 4;
    localparam win_t FIRST_WIN = {32'd0, 32'd0, 32'd0, 32'd0, 32'd0, 32'd1, 32'd0, 32'd4, 32'd5};
    localparam win_t LAST_WIN  = {32'd10, 32'd11, 32'd0, 32'd14, 32'd15, 32'd0, 32'd0, 32'd0, 32'd0};
`else
    localparam int   OH = 2;
    localparam int   OW = 2;
    localparam int   EXP_READS = 9;
    localparam win_t FIRST_WIN = {32'd0, 32'd1, 32'd2, 32'd4, 32'd5, 32'd6, 32'd8, 32'd9, 32'd10};
    localparam win_t LAST_WIN  = {32'd5, 32'd6, 32'd7, 32'd9, 32'd10, 32'd11, 32'd13, 32'd14, 32'd15};
`endif
    localparam int NPOS = OH * OW;

    logic          clk = 1'b0;
    logic          rst_n;
    logic          start, busy, done, mem_rd_en, win_valid, out_valid, out_ready;
    logic [AW-1:0] mem_addr, out_row, out_col;
    logic [31:0]   mem_rdata;
    win_t          win_data;

    logic          start1, busy1, done1, mem_rd_en1, win_valid1, out_valid1;
    logic          out_ready1 = 1'b1;
    logic [AW-1:0] mem_addr1, out_row1, out_col1;
    logic [31:0]   mem_rdata1;
    win_t          win_data1;

    int   cyc = 0;
    int   nTests = 0;
    int   nFails = 0;
    win_t winQ[$];
    logic [7:0] tagQ[$];

    int   passId = 0;
    int   startCyc = 0;
    bit   checkPeriod = 0;

    int   monPass = 0;
    bit   firstPending = 0;
    bit   outSeen = 0;
    int   rdCount = 0;
    int   lastWinCyc = 0;
    int   winCount = 0;
    int   hsCount = 0;
    int   doneCount = 0;
    win_t firstWinCap = '0;
    win_t lastWinCap = '0;

    int   lastWin1 = 0;
    int   hs1 = 0;
    int   done1Count = 0;
    bit   firstWin1Seen = 0;

    conv1_sched #(.IMG_W(W), .IMG_H(H), .FILT_LAT(FL), .ADDR_W(AW)) dut (
        .clk(clk), .rst_n(rst_n), .start(start), .busy(busy), .done(done),
        .mem_rd_en(mem_rd_en), .mem_addr(mem_addr), .mem_rdata(mem_rdata),
        .win_data(win_data), .win_valid(win_valid), .out_valid(out_valid),
        .out_ready(out_ready), .out_row(out_row), .out_col(out_col)
    );

    conv1_sched #(.IMG_W(W), .IMG_H(H), .FILT_LAT(1), .ADDR_W(AW)) dut1 (
        .clk(clk), .rst_n(rst_n), .start(start1), .busy(busy1), .done(done1),
        .mem_rd_en(mem_rd_en1), .mem_addr(mem_addr1), .mem_rdata(mem_rdata1),
        .win_data(win_data1), .win_valid(win_valid1), .out_valid(out_valid1),
        .out_ready(out_ready1), .out_row(out_row1), .out_col(out_col1)
    );

    always #5 clk = ~clk;

    always @(posedge clk) cyc <= cyc + 1;

    // Memories return word[a] = a one cycle after a read and junk otherwise, so stale captures show up.
    always @(posedge clk) begin
        mem_rdata  <= mem_rd_en  ? 32'(mem_addr)  : 32'hDEADBEEF;
        mem_rdata1 <= mem_rd_en1 ? 32'(mem_addr1) : 32'hDEADBEEF;
    end

    task automatic checkOutput(input string name, input logic [63:0] act, input logic [63:0] exp);
        nTests++;
        if (act !== exp) begin
            nFails++;
            $display("[TB] FAIL %s: got %0h, expected %0h (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    task automatic checkWindow(input string name, input win_t act, input win_t exp);
        nTests++;
        if (act !== exp) begin
            nFails++;
            $display("[TB] FAIL %s: got %h, expected %h (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    // Reference window: tap k reads pixel (r+dy, c+dx), or (r-1+dy, c-1+dx) with zero padding.
    function automatic win_t expWindow(input int r, input int c);
        win_t w;
        for (int k = 0; k < 9; k++) begin
`ifdef CONV1_PAD_EN
            int sr = r - 1 + k / 3;
            int sc = c - 1 + k % 3;
            w[k] = (sr >= 0 && sr < H && sc >= 0 && sc < W) ? 32'(sr * W + sc) : 32'd0;
`else
            w[k] = 32'((r + k / 3) * W + (c + k % 3));
`endif
        end
        return w;
    endfunction

    task automatic applyStimulus(input bit withLat1);
        for (int p = 0; p < NPOS; p++) begin
            winQ.push_back(expWindow(p / OW, p % OW));
            tagQ.push_back({4'(p / OW), 4'(p % OW)});
        end
        @(posedge clk); #1;
        start  = 1'b1;
        start1 = withLat1;
        @(posedge clk); #1;
        start    = 1'b0;
        start1   = 1'b0;
        startCyc = cyc;
        passId++;
        checkOutput("busy_after_start", 64'(busy), 64'd1);
    endtask

    task automatic waitDone(input int prevDone, input int budget);
        int n = 0;
        while (doneCount == prevDone && n < budget) begin
            @(posedge clk); #1;
            n++;
        end
        checkOutput("done_in_time", 64'(doneCount != prevDone), 64'd1);
        repeat (3) @(posedge clk);
        #1;
    endtask

    // Monitor for the main instance: pops the scoreboard on every window and every output handshake.
    always @(negedge clk) begin
        if (!rst_n) begin
            winQ.delete();
            tagQ.delete();
            outSeen <= 1'b0;
        end else begin
            if (passId != monPass) begin
                monPass      = passId;
                firstPending = 1'b1;
                rdCount      = 0;
            end
            if (mem_rd_en && firstPending) rdCount++;
            if (win_valid) begin
                if (winQ.size() == 0) begin
                    checkWindow("unexpected_window", win_data, '0);
                end else begin
                    checkWindow("window", win_data, winQ.pop_front());
                end
                if (firstPending) begin
                    checkOutput("first_win_latency", 64'(cyc - startCyc + 1), 64'd11);
                    checkOutput("first_win_reads", 64'(rdCount), 64'(EXP_READS));
                    firstWinCap  = win_data;
                    firstPending = 1'b0;
                end else if (checkPeriod) begin
                    checkOutput("win_period", 64'(cyc - lastWinCyc), 64'(11 + FL));
                end
                lastWinCap = win_data;
                lastWinCyc = cyc;
                winCount++;
            end
            if (out_valid) begin
                if (!outSeen) begin
                    checkOutput("win_to_out_gap", 64'(cyc - lastWinCyc), 64'(FL));
                    outSeen <= 1'b1;
                end
                if (out_ready) begin
                    if (tagQ.size() == 0) begin
                        checkOutput("unexpected_output", 64'({out_row, out_col}), 64'hFFFF);
                    end else begin
                        checkOutput("out_tag", 64'({out_row, out_col}), 64'(tagQ.pop_front()));
                    end
                    hsCount++;
                    outSeen <= 1'b0;
                end
            end
            if (done) doneCount++;
        end
    end

    // Monitor for the FILT_LAT=1 instance, which only runs the first pass.
    always @(negedge clk) begin
        if (rst_n) begin
            if (win_valid1) begin
                lastWin1 = cyc;
                if (!firstWin1Seen) begin
                    checkWindow("lat1_first_window", win_data1, FIRST_WIN);
                    firstWin1Seen = 1'b1;
                end
            end
            if (out_valid1) begin
                checkOutput("lat1_win_to_out_gap", 64'(cyc - lastWin1), 64'd1);
                if (hs1 < NPOS) begin
                    checkOutput("lat1_out_tag", 64'({out_row1, out_col1}), 64'({4'(hs1 / OW), 4'(hs1 % OW)}));
                end
                hs1++;
            end
            if (done1) done1Count++;
        end
    end

    initial begin
        #1000000;
        $display("[TB] FAIL watchdog: simulation did not finish (cycle %0d)", cyc);
        $fatal(1, "[TB] watchdog expired");
    end

    initial begin
        int hBase;
        int dBase;
        int wBase;
        int n;
        logic [7:0] heldTag;

        rst_n     = 1'b0;
        start     = 1'b0;
        start1    = 1'b0;
        out_ready = 1'b1;
        repeat (3) @(posedge clk);
        #1;
        checkOutput("reset_busy", 64'(busy), 64'd0);
        checkOutput("reset_done", 64'(done), 64'd0);
        checkOutput("reset_rd_en", 64'(mem_rd_en), 64'd0);
        checkOutput("reset_addr", 64'(mem_addr), 64'd0);
        checkOutput("reset_win_valid", 64'(win_valid), 64'd0);
        checkOutput("reset_out_valid", 64'(out_valid), 64'd0);
        checkOutput("reset_tag", 64'({out_row, out_col}), 64'd0);
        checkWindow("reset_window", win_data, '0);
        rst_n = 1'b1;
        repeat (2) @(posedge clk);
        #1;

        $display("[TB] single pass with FILT_LAT=%0d and FILT_LAT=1", FL);
        checkPeriod = 1'b1;
        applyStimulus(1'b1);
        waitDone(0, NPOS * 13 + 40);
        checkPeriod = 1'b0;
        checkOutput("pass1_handshakes", 64'(hsCount), 64'(NPOS));
        checkOutput("pass1_done_count", 64'(doneCount), 64'd1);
        checkOutput("pass1_busy_end", 64'(busy), 64'd0);
        checkWindow("pass1_first_window", firstWinCap, FIRST_WIN);
        checkWindow("pass1_last_window", lastWinCap, LAST_WIN);
        checkOutput("lat1_handshakes", 64'(hs1), 64'(NPOS));
        checkOutput("lat1_done_count", 64'(done1Count), 64'd1);
        checkOutput("lat1_busy_end", 64'(busy1), 64'd0);

        $display("[TB] backpressure at position (0,1)");
        hBase = hsCount;
        dBase = doneCount;
        wBase = winCount;
        applyStimulus(1'b0);
        n = 0;
        while (winCount < wBase + 2 && n < 80) begin
            @(posedge clk); #1;
            n++;
        end
        checkOutput("second_window_seen", 64'(winCount >= wBase + 2), 64'd1);
        out_ready = 1'b0;
        n = 0;
        while (!out_valid && n < 10) begin
            @(posedge clk); #1;
            n++;
        end
        heldTag = {out_row, out_col};
        checkOutput("stall_tag", 64'(heldTag), 64'h01);
        for (int i = 0; i < 20; i++) begin
            @(posedge clk); #1;
            checkOutput("stall_out_valid", 64'(out_valid), 64'd1);
            checkOutput("stall_tag_stable", 64'({out_row, out_col}), 64'h01);
            checkOutput("stall_no_read", 64'(mem_rd_en), 64'd0);
        end
        out_ready = 1'b1;
        waitDone(dBase, NPOS * 13 + 40);
        checkOutput("bp_handshakes", 64'(hsCount - hBase), 64'(NPOS));
        checkOutput("bp_done_count", 64'(doneCount - dBase), 64'd1);

        $display("[TB] start while busy and in the DONE cycle");
        hBase = hsCount;
        dBase = doneCount;
        applyStimulus(1'b0);
        repeat (5) @(posedge clk);
        #1;
        start = 1'b1;
        repeat (3) @(posedge clk);
        #1;
        start = 1'b0;
        n = 0;
        while (!done && n < NPOS * 13 + 40) begin
            @(posedge clk); #1;
            n++;
        end
        checkOutput("done_seen", 64'(done), 64'd1);
        start = 1'b1;
        @(posedge clk); #1;
        start = 1'b0;
        checkOutput("done_start_ignored", 64'(busy), 64'd0);
        repeat (20) @(posedge clk);
        #1;
        checkOutput("ignore_busy_idle", 64'(busy), 64'd0);
        checkOutput("ignore_handshakes", 64'(hsCount - hBase), 64'(NPOS));
        checkOutput("ignore_done_count", 64'(doneCount - dBase), 64'd1);
        checkOutput("ignore_queue_empty", 64'(winQ.size()), 64'd0);

        $display("[TB] reset during fetch of position (1,0)");
        hBase = hsCount;
        dBase = doneCount;
        applyStimulus(1'b0);
        n = 0;
        while (hsCount < hBase + OW && n < NPOS * 13 + 40) begin
            @(posedge clk); #1;
            n++;
        end
        @(posedge clk); #1;
        checkOutput("pre_reset_tag", 64'({out_row, out_col}), 64'h10);
        checkOutput("pre_reset_rd_en", 64'(mem_rd_en), 64'd1);
        #2;
        rst_n = 1'b0;
        #1;
        checkOutput("abort_busy", 64'(busy), 64'd0);
        checkOutput("abort_rd_en", 64'(mem_rd_en), 64'd0);
        checkOutput("abort_addr", 64'(mem_addr), 64'd0);
        checkOutput("abort_out_valid", 64'(out_valid), 64'd0);
        checkOutput("abort_win_valid", 64'(win_valid), 64'd0);
        checkOutput("abort_tag", 64'({out_row, out_col}), 64'd0);
        checkWindow("abort_window", win_data, '0);
        repeat (2) @(posedge clk);
        #3;
        rst_n = 1'b1;
        repeat (2) @(posedge clk);
        #1;
        checkOutput("abort_no_done", 64'(doneCount - dBase), 64'd0);
        hBase = hsCount;
        applyStimulus(1'b0);
        waitDone(dBase, NPOS * 13 + 40);
        checkOutput("restart_handshakes", 64'(hsCount - hBase), 64'(NPOS));
        checkOutput("restart_done_count", 64'(doneCount - dBase), 64'd1);
        checkWindow("restart_first_window", firstWinCap, FIRST_WIN);

        $display("[TB] %0d tests run, %0d failed", nTests, nFails);
        $finish;
    end

endmodule
